// File: rtl/riscv_core_st_align_if.sv
// Store-alignment bus: core-side request channel plus cache-side write-beat channel.
// Handshakes on both channels are valid/ready: a transfer happens on a rising clock
// edge where valid and ready are both 1; once valid is raised, the payload holds
// steady until that transfer edge.
interface riscv_core_st_align_if #(
    parameter int XLEN = 64
);
    logic            i_stalign_valid;
    logic            o_stalign_ready;
    logic [XLEN-1:0] i_stalign_addr;
    logic [1:0]      i_stalign_size;
    logic [XLEN-1:0] i_stalign_wdata;
    logic            o_stalign_mem_valid;
    logic            i_stalign_mem_ready;
    logic [XLEN-1:0] o_stalign_mem_addr;
    logic [XLEN-1:0] o_stalign_mem_wdata;
    logic [7:0]      o_stalign_mem_strb;
    logic            o_stalign_split;
    logic            o_stalign_done;

    // Aligner side.
    modport slave (
        input  i_stalign_valid, i_stalign_addr, i_stalign_size, i_stalign_wdata,
        input  i_stalign_mem_ready,
        output o_stalign_ready, o_stalign_mem_valid, o_stalign_mem_addr,
        output o_stalign_mem_wdata, o_stalign_mem_strb, o_stalign_split, o_stalign_done
    );

    // Core / cache side.
    modport master (
        output i_stalign_valid, i_stalign_addr, i_stalign_size, i_stalign_wdata,
        output i_stalign_mem_ready,
        input  o_stalign_ready, o_stalign_mem_valid, o_stalign_mem_addr,
        input  o_stalign_mem_wdata, o_stalign_mem_strb, o_stalign_split, o_stalign_done
    );
endinterface

// File: rtl/riscv_core_st_align.sv
// Store aligner: turns a right-justified store of 1/2/4/8 bytes at any byte address
// into one or two doubleword-aligned, byte-strobed write beats for the data cache.
module riscv_core_st_align #(
    parameter int XLEN = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    riscv_core_st_align_if.slave  bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            split_q, split_d;
    logic            done_q, done_d;

    logic [3:0]      req_span;
    logic            req_split;
    logic [2:0]      cur_off;
    logic [3:0]      cur_span;
    logic [3:0]      beat1_shift;
    logic [XLEN-1:0] base_addr;
    logic [7:0]      strb0, strb1;
    logic [XLEN-1:0] mask0, mask1;

    // Split decision for the incoming request: it crosses a doubleword when off+nb > 8.
    always_comb begin
        req_span  = {1'b0, bus.i_stalign_addr[2:0]} + (4'd1 << bus.i_stalign_size);
        req_split = (req_span > 4'd8);
    end

    // Beat geometry derived from the captured request.
    always_comb begin
        cur_off     = addr_q[2:0];
        cur_span    = {1'b0, cur_off} + (4'd1 << size_q);
        beat1_shift = 4'd8 - {1'b0, cur_off};
        base_addr   = {addr_q[XLEN-1:3], 3'b000};
        strb0       = '0;
        strb1       = '0;
        mask0       = '0;
        mask1       = '0;
        for (int k = 0; k < 8; k++) begin
            strb0[k] = (4'(k) >= {1'b0, cur_off}) && (4'(k) < cur_span);
            strb1[k] = ((4'(k) + 4'd8) < cur_span);
            mask0[8*k +: 8] = {8{strb0[k]}};
            mask1[8*k +: 8] = {8{strb1[k]}};
        end
    end

    // State and captured-request registers; reset abandons any request in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            done_q  <= done_d;
        end
    end

    // Next state: accept in IDLE, advance a beat on each cache handshake.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        split_d = split_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_stalign_valid) begin
                    addr_d  = bus.i_stalign_addr;
                    size_d  = bus.i_stalign_size;
                    wdata_d = bus.i_stalign_wdata;
                    split_d = req_split;
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (bus.i_stalign_mem_ready) begin
                    if (split_q) begin
                        state_d = ST_BEAT1;
                    end else begin
                        state_d = ST_IDLE;
                        split_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus.i_stalign_mem_ready) begin
                    state_d = ST_IDLE;
                    split_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                split_d = 1'b0;
            end
        endcase
    end

    // Outputs: beat payload is a pure function of state and captured request, so it
    // stays frozen while the cache stalls. Non-strobed lanes are driven as zero.
    always_comb begin
        bus.o_stalign_ready     = (state_q == ST_IDLE);
        bus.o_stalign_mem_valid = 1'b0;
        bus.o_stalign_mem_addr  = '0;
        bus.o_stalign_mem_wdata = '0;
        bus.o_stalign_mem_strb  = '0;
        bus.o_stalign_split     = split_q;
        bus.o_stalign_done      = done_q;
        o_dbg_state             = state_q;
        case (state_q)
            ST_BEAT0: begin
                bus.o_stalign_mem_valid = 1'b1;
                bus.o_stalign_mem_addr  = base_addr;
                bus.o_stalign_mem_wdata = (wdata_q << {cur_off, 3'b000}) & mask0;
                bus.o_stalign_mem_strb  = strb0;
            end
            ST_BEAT1: begin
                bus.o_stalign_mem_valid = 1'b1;
                bus.o_stalign_mem_addr  = base_addr + XLEN'(8);
                bus.o_stalign_mem_wdata = (wdata_q >> {beat1_shift, 3'b000}) & mask1;
                bus.o_stalign_mem_strb  = strb1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_core_st_align.sv
// Directed bench for the store aligner: reset, aligned/misaligned/split stores,
// cache stall, reset mid-request, address wrap and a back-to-back random burst.
module tb_riscv_core_st_align;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_vec;
    int         n_err;

    riscv_core_st_align_if #(.XLEN(64)) bus ();

    riscv_core_st_align #(.XLEN(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_req(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        bus.i_stalign_valid = 1'b1;
        bus.i_stalign_addr  = a;
        bus.i_stalign_size  = s;
        bus.i_stalign_wdata = d;
    endtask

    task automatic drop_req();
        bus.i_stalign_valid = 1'b0;
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] s);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    // Reference model for random requests, built from byte offsets.
    function automatic logic [7:0] model_strb(input int beat, input logic [63:0] a, input logic [1:0] s);
        int off, span;
        logic [7:0] r;
        off  = int'(a[2:0]);
        span = off + (1 << s);
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (beat == 0) r[k] = (k >= off) && (k < span) && (k < 8);
            else           r[k] = (k < span - 8);
        end
        return r;
    endfunction

    function automatic logic [63:0] model_data(input int beat, input logic [63:0] a,
                                               input logic [1:0] s, input logic [63:0] d);
        int off, src;
        logic [7:0] st;
        logic [63:0] r;
        off = int'(a[2:0]);
        st  = model_strb(beat, a, s);
        r   = '0;
        for (int k = 0; k < 8; k++) begin
            if (st[k]) begin
                src = (beat == 0) ? (k - off) : (k + 8 - off);
                r[8*k +: 8] = d[8*src +: 8];
            end
        end
        return r;
    endfunction

    logic [63:0] r_addr [10];
    logic [1:0]  r_size [10];
    logic [63:0] r_data [10];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_stalign_valid     = 1'b0;
        bus.i_stalign_addr      = '0;
        bus.i_stalign_size      = '0;
        bus.i_stalign_wdata     = '0;
        bus.i_stalign_mem_ready = 1'b1;

        // Reset state.
        #1;
        chk("rst_ready", 64'(bus.o_stalign_ready), 64'd1);
        chk("rst_mem_valid", 64'(bus.o_stalign_mem_valid), 64'd0);
        chk("rst_done", 64'(bus.o_stalign_done), 64'd0);
        chk("rst_split", 64'(bus.o_stalign_split), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        step();
        step();
        rst = 1'b0;

        // SD aligned: one beat, full strobe, done at N+2.
        drive_req(64'h1000, 2'b11, 64'h1122334455667788);
        step();
        drop_req();
        chk("sd_mem_valid", 64'(bus.o_stalign_mem_valid), 64'd1);
        chk("sd_ready", 64'(bus.o_stalign_ready), 64'd0);
        chk("sd_addr", bus.o_stalign_mem_addr, 64'h1000);
        chk("sd_strb", 64'(bus.o_stalign_mem_strb), 64'hFF);
        chk("sd_wdata", bus.o_stalign_mem_wdata, 64'h1122334455667788);
        chk("sd_split", 64'(bus.o_stalign_split), 64'd0);
        chk("sd_done_early", 64'(bus.o_stalign_done), 64'd0);
        step();
        chk("sd_done", 64'(bus.o_stalign_done), 64'd1);
        chk("sd_ready_back", 64'(bus.o_stalign_ready), 64'd1);
        chk("sd_mem_valid_off", 64'(bus.o_stalign_mem_valid), 64'd0);
        step();
        chk("sd_done_pulse", 64'(bus.o_stalign_done), 64'd0);

        // SB at offset 5.
        drive_req(64'h2005, 2'b00, 64'hAB);
        step();
        drop_req();
        chk("sb_addr", bus.o_stalign_mem_addr, 64'h2000);
        chk("sb_strb", 64'(bus.o_stalign_mem_strb), 64'h20);
        chk("sb_wdata", bus.o_stalign_mem_wdata & lanes(8'h20), 64'h0000_AB00_0000_0000);
        chk("sb_split", 64'(bus.o_stalign_split), 64'd0);
        step();
        chk("sb_done", 64'(bus.o_stalign_done), 64'd1);

        // SW at offset 6: split across two doublewords, done at N+3.
        drive_req(64'h3006, 2'b10, 64'hDEADBEEF);
        step();
        drop_req();
        chk("sw_b0_addr", bus.o_stalign_mem_addr, 64'h3000);
        chk("sw_b0_strb", 64'(bus.o_stalign_mem_strb), 64'hC0);
        chk("sw_b0_wdata", bus.o_stalign_mem_wdata & lanes(8'hC0), 64'hBEEF_0000_0000_0000);
        chk("sw_b0_split", 64'(bus.o_stalign_split), 64'd1);
        step();
        chk("sw_b1_valid", 64'(bus.o_stalign_mem_valid), 64'd1);
        chk("sw_b1_addr", bus.o_stalign_mem_addr, 64'h3008);
        chk("sw_b1_strb", 64'(bus.o_stalign_mem_strb), 64'h03);
        chk("sw_b1_wdata", bus.o_stalign_mem_wdata & lanes(8'h03), 64'h0000_0000_0000_DEAD);
        chk("sw_b1_split", 64'(bus.o_stalign_split), 64'd1);
        chk("sw_b1_done", 64'(bus.o_stalign_done), 64'd0);
        step();
        chk("sw_done", 64'(bus.o_stalign_done), 64'd1);
        chk("sw_split_clr", 64'(bus.o_stalign_split), 64'd0);
        chk("sw_ready", 64'(bus.o_stalign_ready), 64'd1);

        // SH at offset 7 with the cache stalled for 5 cycles.
        bus.i_stalign_mem_ready = 1'b0;
        drive_req(64'h4007, 2'b01, 64'h5A69);
        step();
        drop_req();
        for (int c = 0; c < 5; c++) begin
            chk("sh_stall_valid", 64'(bus.o_stalign_mem_valid), 64'd1);
            chk("sh_stall_addr", bus.o_stalign_mem_addr, 64'h4000);
            chk("sh_stall_strb", 64'(bus.o_stalign_mem_strb), 64'h80);
            chk("sh_stall_wdata", bus.o_stalign_mem_wdata & lanes(8'h80), 64'h6900_0000_0000_0000);
            chk("sh_stall_done", 64'(bus.o_stalign_done), 64'd0);
            if (c < 4) step();
        end
        bus.i_stalign_mem_ready = 1'b1;
        step();
        chk("sh_b1_addr", bus.o_stalign_mem_addr, 64'h4008);
        chk("sh_b1_strb", 64'(bus.o_stalign_mem_strb), 64'h01);
        chk("sh_b1_wdata", bus.o_stalign_mem_wdata & lanes(8'h01), 64'h5A);
        chk("sh_b1_done", 64'(bus.o_stalign_done), 64'd0);
        step();
        chk("sh_done", 64'(bus.o_stalign_done), 64'd1);
        step();
        chk("sh_done_once", 64'(bus.o_stalign_done), 64'd0);

        // Reset during BEAT1 of the split SW request.
        drive_req(64'h3006, 2'b10, 64'hDEADBEEF);
        step();
        drop_req();
        step();
        chk("rb1_state", 64'(dbg_state), 64'd2);
        rst = 1'b1;
        #1;
        chk("rb1_mem_valid", 64'(bus.o_stalign_mem_valid), 64'd0);
        chk("rb1_ready", 64'(bus.o_stalign_ready), 64'd1);
        chk("rb1_split", 64'(bus.o_stalign_split), 64'd0);
        step();
        chk("rb1_no_done", 64'(bus.o_stalign_done), 64'd0);
        rst = 1'b0;
        step();
        chk("rb1_no_done2", 64'(bus.o_stalign_done), 64'd0);
        drive_req(64'h2005, 2'b00, 64'h77);
        step();
        drop_req();
        chk("rb1_sb_strb", 64'(bus.o_stalign_mem_strb), 64'h20);
        chk("rb1_sb_wdata", bus.o_stalign_mem_wdata & lanes(8'h20), 64'h0000_7700_0000_0000);
        step();
        chk("rb1_sb_done", 64'(bus.o_stalign_done), 64'd1);

        // SD at the top of the address space: beat 1 wraps to address 0.
        drive_req(64'hFFFF_FFFF_FFFF_FFF9, 2'b11, 64'h0102030405060708);
        step();
        drop_req();
        chk("wrap_b0_addr", bus.o_stalign_mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_b0_strb", 64'(bus.o_stalign_mem_strb), 64'hFE);
        chk("wrap_b0_wdata", bus.o_stalign_mem_wdata & lanes(8'hFE), 64'h0203040506070800);
        step();
        chk("wrap_b1_addr", bus.o_stalign_mem_addr, 64'h0);
        chk("wrap_b1_strb", 64'(bus.o_stalign_mem_strb), 64'h01);
        chk("wrap_b1_wdata", bus.o_stalign_mem_wdata & lanes(8'h01), 64'h01);
        step();
        chk("wrap_done", 64'(bus.o_stalign_done), 64'd1);

        // Ten back-to-back random requests with valid held high.
        for (int i = 0; i < 10; i++) begin
            r_addr[i] = {$urandom, $urandom};
            r_size[i] = 2'($urandom_range(0, 3));
            r_data[i] = {$urandom, $urandom};
        end
        drive_req(r_addr[0], r_size[0], r_data[0]);
        for (int i = 0; i < 10; i++) begin
            logic [63:0] base;
            logic [7:0]  s0, s1;
            logic        spl;
            base = {r_addr[i][63:3], 3'b000};
            s0   = model_strb(0, r_addr[i], r_size[i]);
            s1   = model_strb(1, r_addr[i], r_size[i]);
            spl  = (int'(r_addr[i][2:0]) + (1 << r_size[i])) > 8;
            step();
            // Next request is presented early; it must be ignored until done.
            if (i < 9) drive_req(r_addr[i+1], r_size[i+1], r_data[i+1]);
            else       drop_req();
            chk("b2b_b0_valid", 64'(bus.o_stalign_mem_valid), 64'd1);
            chk("b2b_b0_addr", bus.o_stalign_mem_addr, base);
            chk("b2b_b0_strb", 64'(bus.o_stalign_mem_strb), 64'(s0));
            chk("b2b_b0_wdata", bus.o_stalign_mem_wdata & lanes(s0),
                model_data(0, r_addr[i], r_size[i], r_data[i]));
            chk("b2b_split", 64'(bus.o_stalign_split), 64'(spl));
            if (spl) begin
                step();
                chk("b2b_b1_valid", 64'(bus.o_stalign_mem_valid), 64'd1);
                chk("b2b_b1_addr", bus.o_stalign_mem_addr, base + 64'd8);
                chk("b2b_b1_strb", 64'(bus.o_stalign_mem_strb), 64'(s1));
                chk("b2b_b1_wdata", bus.o_stalign_mem_wdata & lanes(s1),
                    model_data(1, r_addr[i], r_size[i], r_data[i]));
            end
            step();
            chk("b2b_done", 64'(bus.o_stalign_done), 64'd1);
            chk("b2b_ready", 64'(bus.o_stalign_ready), 64'd1);
        end
        step();
        chk("b2b_idle", 64'(bus.o_stalign_mem_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
